// File: rtl/sig_ctrl_if.sv
// Config handshake bundle between the button pulse stage, sig_ctrl and the NCO.
// master: pulse/ready driver side; slave: sig_ctrl.
interface sig_ctrl_if #(
    parameter int IDX_W = 4,
    parameter int INC_W = 32
);
    logic             up_p;
    logic             dn_p;
    logic             wave_p;
    logic             cfg_ready;
    logic             cfg_valid;
    logic [1:0]       wave_sel;
    logic [IDX_W-1:0] freq_idx;
    logic [INC_W-1:0] phase_inc;

    modport master (
        output up_p, dn_p, wave_p, cfg_ready,
        input  cfg_valid, wave_sel, freq_idx, phase_inc
    );

    modport slave (
        input  up_p, dn_p, wave_p, cfg_ready,
        output cfg_valid, wave_sel, freq_idx, phase_inc
    );
endinterface

// File: rtl/sig_ctrl.sv
// Frequency-step / waveform control for the NCO with a coalescing valid/ready config word.
// Optional macro SIG_CTRL_WRAP_EN: index wraps at the ends instead of saturating.
module sig_ctrl #(
    parameter int               IDX_W     = 4,
    parameter int               INC_W     = 32,
    parameter logic [INC_W-1:0] BASE_INC  = 32'h0000_1000,
    parameter int unsigned      RESET_IDX = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    sig_ctrl_if.slave bus
);
    typedef enum logic [1:0] {SQUARE = 2'd0, TRIANGLE = 2'd1, SAW = 2'd2, SINE = 2'd3} wave_t;

    localparam logic [IDX_W-1:0] IDX_MAX = '1;
    localparam logic [IDX_W-1:0] IDX_RST = IDX_W'(RESET_IDX);
    localparam logic [INC_W-1:0] INC_RST = BASE_INC << RESET_IDX;

    wave_t            r_wave, w_wave_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic [INC_W-1:0] r_inc;
    logic             r_vld;
    logic             w_idx_chg, w_chg;

    // Waveform FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_wave <= SQUARE;
        else        r_wave <= w_wave_nxt;
    end

    // Waveform FSM: next state
    always_comb begin
        w_wave_nxt = r_wave;
        if (bus.wave_p) begin
            case (r_wave)
                SQUARE:   w_wave_nxt = TRIANGLE;
                TRIANGLE: w_wave_nxt = SAW;
                SAW:      w_wave_nxt = SINE;
                default:  w_wave_nxt = SQUARE;
            endcase
        end
    end

    // Waveform FSM: output, straight from the state register
    always_comb begin
        bus.wave_sel = r_wave;
    end

    // Only a real index movement counts as a change; saturated no-ops stay silent.
    always_comb begin
        w_idx_nxt = r_idx;
        w_idx_chg = 1'b0;
        if (bus.up_p && !bus.dn_p) begin
            if (r_idx != IDX_MAX) begin
                w_idx_nxt = r_idx + IDX_W'(1);
                w_idx_chg = 1'b1;
            end else begin
`ifdef SIG_CTRL_WRAP_EN
                w_idx_nxt = '0;
                w_idx_chg = 1'b1;
`else
                w_idx_nxt = r_idx;
`endif
            end
        end else if (bus.dn_p && !bus.up_p) begin
            if (r_idx != '0) begin
                w_idx_nxt = r_idx - IDX_W'(1);
                w_idx_chg = 1'b1;
            end else begin
`ifdef SIG_CTRL_WRAP_EN
                w_idx_nxt = IDX_MAX;
                w_idx_chg = 1'b1;
`else
                w_idx_nxt = r_idx;
`endif
            end
        end
    end

    assign w_chg = w_idx_chg | bus.wave_p;

    // phase_inc is built from the next index so it never lags freq_idx.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= IDX_RST;
            r_inc <= INC_RST;
            r_vld <= 1'b1;
        end else begin
            r_idx <= w_idx_nxt;
            r_inc <= BASE_INC << w_idx_nxt;
            r_vld <= w_chg | (r_vld & ~bus.cfg_ready);
        end
    end

    assign bus.freq_idx  = r_idx;
    assign bus.phase_inc = r_inc;
    assign bus.cfg_valid = r_vld;
endmodule

// File: tb/tb_sig_ctrl.sv
// Scoreboard bench for sig_ctrl: expected config pushed per driven cycle, checked after the edge.
module tb_sig_ctrl;
    localparam int IDX_W = 4;
    localparam int INC_W = 32;
    localparam logic [31:0] BASE = 32'h0000_1000;

    typedef struct {
        logic [1:0]       wave;
        logic [IDX_W-1:0] idx;
        logic [INC_W-1:0] inc;
        logic             vld;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];
    exp_t e;

    logic [1:0]       m_wave;
    logic [IDX_W-1:0] m_idx;
    logic             m_vld;

    sig_ctrl_if #(.IDX_W(IDX_W), .INC_W(INC_W)) bus ();

    sig_ctrl #(.IDX_W(IDX_W), .INC_W(INC_W), .BASE_INC(BASE), .RESET_IDX(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [INC_W-1:0] calc_inc(input logic [IDX_W-1:0] idx);
        logic [INC_W-1:0] b;
        b = BASE;
        return b << idx;
    endfunction

    // Scoreboard monitor
    always @(posedge clk) begin
        #1;
        if (rst_n && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_vec++;
            if (bus.wave_sel !== e.wave) begin
                n_err++; $display("FAIL sb_wave got %0d want %0d", bus.wave_sel, e.wave);
            end
            n_vec++;
            if (bus.freq_idx !== e.idx) begin
                n_err++; $display("FAIL sb_idx got %0d want %0d", bus.freq_idx, e.idx);
            end
            n_vec++;
            if (bus.phase_inc !== e.inc) begin
                n_err++; $display("FAIL sb_inc got %h want %h", bus.phase_inc, e.inc);
            end
            n_vec++;
            if (bus.cfg_valid !== e.vld) begin
                n_err++; $display("FAIL sb_vld got %0b want %0b", bus.cfg_valid, e.vld);
            end
        end
    end

    task automatic step(input logic u, input logic d, input logic w, input logic r);
        logic chg;
        @(negedge clk);
        bus.up_p = u; bus.dn_p = d; bus.wave_p = w; bus.cfg_ready = r;
        chg = 1'b0;
        if (u && !d) begin
            if (m_idx != 4'd15) begin m_idx = m_idx + 4'd1; chg = 1'b1; end
`ifdef SIG_CTRL_WRAP_EN
            else begin m_idx = 4'd0; chg = 1'b1; end
`endif
        end else if (d && !u) begin
            if (m_idx != 4'd0) begin m_idx = m_idx - 4'd1; chg = 1'b1; end
`ifdef SIG_CTRL_WRAP_EN
            else begin m_idx = 4'd15; chg = 1'b1; end
`endif
        end
        if (w) begin m_wave = m_wave + 2'd1; chg = 1'b1; end
        m_vld = chg | (m_vld & ~r);
        sb_q.push_back('{wave: m_wave, idx: m_idx, inc: calc_inc(m_idx), vld: m_vld});
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        bus.up_p = 0; bus.dn_p = 0; bus.wave_p = 0; bus.cfg_ready = 0;
        rst_n = 1'b0;
        m_wave = 2'd0; m_idx = 4'd4; m_vld = 1'b1;
        sb_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (bus.wave_sel !== 2'd0 || bus.freq_idx !== 4'd4 || bus.phase_inc !== 32'h0001_0000 || bus.cfg_valid !== 1'b1) begin
            n_err++;
            $display("FAIL reset_vals got w=%0d i=%0d inc=%h v=%0b want 0 4 00010000 1",
                     bus.wave_sel, bus.freq_idx, bus.phase_inc, bus.cfg_valid);
        end
        repeat (3) step(0, 0, 0, 0);
        n_vec++;
        if (bus.cfg_valid !== 1'b1) begin n_err++; $display("FAIL reset_hold got %0b want 1", bus.cfg_valid); end
        step(0, 0, 0, 1);
        n_vec++;
        if (bus.cfg_valid !== 1'b0) begin n_err++; $display("FAIL reset_accept got %0b want 0", bus.cfg_valid); end
        step(0, 0, 0, 1);
    endtask

    task automatic test_up_steps();
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0);
            n_vec++;
            if (bus.freq_idx !== 4'(5 + i) || bus.cfg_valid !== 1'b1) begin
                n_err++; $display("FAIL up_step%0d got i=%0d v=%0b want %0d 1", i, bus.freq_idx, bus.cfg_valid, 5 + i);
            end
            step(0, 0, 0, 1);
        end
        n_vec++;
        if (bus.phase_inc !== 32'h0008_0000 || bus.cfg_valid !== 1'b0) begin
            n_err++; $display("FAIL up_final got inc=%h v=%0b want 00080000 0", bus.phase_inc, bus.cfg_valid);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        step(0, 0, 0, 1);
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 0, 1);
`ifdef SIG_CTRL_WRAP_EN
            if (i == 11) begin
                n_vec++;
                if (bus.freq_idx !== 4'd0 || bus.phase_inc !== 32'h0000_1000 || bus.cfg_valid !== 1'b1) begin
                    n_err++; $display("FAIL wrap_12 got i=%0d inc=%h v=%0b want 0 00001000 1",
                                      bus.freq_idx, bus.phase_inc, bus.cfg_valid);
                end
            end
`endif
        end
`ifndef SIG_CTRL_WRAP_EN
        n_vec++;
        if (bus.freq_idx !== 4'd15 || bus.phase_inc !== 32'h0800_0000 || bus.cfg_valid !== 1'b0) begin
            n_err++; $display("FAIL saturate got i=%0d inc=%h v=%0b want 15 08000000 0",
                              bus.freq_idx, bus.phase_inc, bus.cfg_valid);
        end
        for (int i = 0; i < 16; i++) step(0, 1, 0, 1);
        n_vec++;
        if (bus.freq_idx !== 4'd0 || bus.cfg_valid !== 1'b0) begin
            n_err++; $display("FAIL sat_low got i=%0d v=%0b want 0 0", bus.freq_idx, bus.cfg_valid);
        end
`endif
    endtask

    task automatic test_simul();
        do_reset();
        step(0, 0, 0, 1);
        step(1, 1, 0, 0);
        n_vec++;
        if (bus.freq_idx !== 4'd4 || bus.cfg_valid !== 1'b0) begin
            n_err++; $display("FAIL up_dn got i=%0d v=%0b want 4 0", bus.freq_idx, bus.cfg_valid);
        end
        step(1, 0, 1, 0);
        n_vec++;
        if (bus.freq_idx !== 4'd5 || bus.wave_sel !== 2'd1 || bus.cfg_valid !== 1'b1) begin
            n_err++; $display("FAIL up_wave got i=%0d w=%0d v=%0b want 5 1 1", bus.freq_idx, bus.wave_sel, bus.cfg_valid);
        end
        step(0, 0, 0, 1);
        n_vec++;
        if (bus.cfg_valid !== 1'b0) begin n_err++; $display("FAIL up_wave_single got %0b want 0", bus.cfg_valid); end
    endtask

    task automatic test_wave();
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
        repeat (2) step(0, 0, 0, 0);
        n_vec++;
        if (bus.wave_sel !== 2'd1 || bus.cfg_valid !== 1'b1) begin
            n_err++; $display("FAIL wave5 got w=%0d v=%0b want 1 1", bus.wave_sel, bus.cfg_valid);
        end
        step(0, 0, 1, 1);
        n_vec++;
        if (bus.wave_sel !== 2'd2 || bus.cfg_valid !== 1'b1) begin
            n_err++; $display("FAIL wave_accept got w=%0d v=%0b want 2 1", bus.wave_sel, bus.cfg_valid);
        end
        step(0, 0, 0, 1);
        n_vec++;
        if (bus.cfg_valid !== 1'b0) begin n_err++; $display("FAIL wave_done got %0b want 0", bus.cfg_valid); end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(0, 0, 0, 1);
        step(1, 0, 0, 1);
        step(1, 0, 1, 1);
        n_vec++;
        if (bus.freq_idx !== 4'd6) begin n_err++; $display("FAIL pre_rst got %0d want 6", bus.freq_idx); end
        #1;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.wave_sel !== 2'd0 || bus.freq_idx !== 4'd4 || bus.phase_inc !== 32'h0001_0000 || bus.cfg_valid !== 1'b1) begin
            n_err++;
            $display("FAIL async_rst got w=%0d i=%0d inc=%h v=%0b want 0 4 00010000 1",
                     bus.wave_sel, bus.freq_idx, bus.phase_inc, bus.cfg_valid);
        end
        do_reset();
        step(0, 0, 0, 0);
        n_vec++;
        if (bus.cfg_valid !== 1'b1) begin n_err++; $display("FAIL post_rst_vld got %0b want 1", bus.cfg_valid); end
        step(1, 0, 0, 1);
        n_vec++;
        if (bus.freq_idx !== 4'd5) begin n_err++; $display("FAIL first_pulse got %0d want 5", bus.freq_idx); end
    endtask

    initial begin
        test_reset();
        test_up_steps();
        test_saturate();
        test_simul();
        test_wave();
        test_async_reset();
        repeat (2) @(posedge clk);
        if (sb_q.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL sb_drain got %0d left want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sig_ctrl.md
# sig_ctrl

Control stage that sits directly downstream of the button debounce/edge detectors. It consumes their single-cycle press pulses and maintains the generator's frequency step and waveform selection. It drives a registered configuration word (waveform, frequency index, phase increment) to the NCO, using a valid/ready handshake so that no change is lost.

## Interface
Parameters:
- `IDX_W`, 4: frequency index width; index range 0..2^IDX_W-1.
- `INC_W`, 32: phase increment width.
- `BASE_INC`, 32'h0000_1000: phase increment at index 0.
- `RESET_IDX`, 4: frequency index after reset.

Ports:
- `clk`, in, 1: sole clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `up_p`, in, 1: single-cycle pulse; step frequency up.
- `dn_p`, in, 1: single-cycle pulse; step frequency down.
- `wave_p`, in, 1: single-cycle pulse; advance waveform.
- `cfg_ready`, in, 1: NCO accepts the current config.
- `cfg_valid`, out, 1: config changed and not yet accepted.
- `wave_sel`, out, 2: 0 SQUARE, 1 TRIANGLE, 2 SAW, 3 SINE.
- `freq_idx`, out, IDX_W: current frequency index.
- `phase_inc`, out, INC_W: `BASE_INC << freq_idx`, truncated to INC_W bits.

## Operation
- All outputs are registered.
- Reset values:
  - `wave_sel` = 0 (SQUARE).
  - `freq_idx` = RESET_IDX.
  - `phase_inc` = `BASE_INC << RESET_IDX`.
  - `cfg_valid` = 1, so the NCO loads the initial config.
- Frequency step, per cycle:
  - `up_p & ~dn_p`: increment index.
  - `dn_p & ~up_p`: decrement index.
  - Both or neither: no change. Simultaneous up/down cancels and counts as no change.
- Index boundaries (default build): saturate. Up at max and down at 0 are no-ops and are not changes.
- Waveform FSM advances one state per `wave_p`: SQUARE→TRIANGLE→SAW→SINE→SQUARE. It is independent of the frequency step; both may change in the same cycle.
- `phase_inc` is recomputed from the next index at the same edge that `freq_idx` updates. It never lags `freq_idx`.
- Change flag `chg` = (index actually changed) | `wave_p`.
- `cfg_valid` next value = `chg` | (`cfg_valid` & ~`cfg_ready`).
  - Accept and new change in the same cycle: `cfg_valid` stays 1 and carries the new values.
  - Changes made while `cfg_valid` is already high coalesce. The outputs always hold the latest state; intermediate states are not queued.
- `cfg_ready` while `cfg_valid` = 0 has no effect.
- Input pulses longer than one cycle are treated as one event per high cycle. No edge detection is done here; that belongs to the upstream stage.
- Reset asserted mid-operation: all registers return to their reset values immediately (asynchronously). A pending handshake is abandoned, and `cfg_valid` = 1 after release.

## Timing
- Latency: a pulse sampled at edge N updates `freq_idx`, `wave_sel`, `phase_inc` and `cfg_valid` at edge N (visible in cycle N+1).
- Handshake completes at the edge where `cfg_valid & cfg_ready`. `cfg_valid` falls at that edge unless `chg` is set in the same cycle.
- Outputs are stable while `cfg_valid` = 1 and no new pulse arrives.
- No combinational path from any input to any output.
- After `rst_n` deasserts, the first pulse is honoured at the first rising edge.

## Configuration
- `SIG_CTRL_WRAP_EN`:
  - Defined: the index wraps. Up at max goes to 0, down at 0 goes to max, and each wrap counts as a change that sets `cfg_valid`.
  - Undefined: the index saturates, as described above.
- Waveform cycling always wraps, with or without the macro.

## Test plan
- Reset, then hold `cfg_ready` = 0: `wave_sel` = 0, `freq_idx` = 4, `phase_inc` = 32'h0001_0000, `cfg_valid` = 1 held. Pulse `cfg_ready` once: `cfg_valid` = 0 at the next edge.
- 3 `up_p` pulses with `cfg_ready` = 1 after each: `freq_idx` goes 5, 6, 7; final `phase_inc` = 32'h0008_0000; `cfg_valid` pulses one cycle per step.
- 20 `up_p` pulses, default build: `freq_idx` saturates at 15, `phase_inc` = 32'h0800_0000, no `cfg_valid` after the saturating step. With `SIG_CTRL_WRAP_EN`: the 12th pulse gives `freq_idx` = 0, `phase_inc` = 32'h0000_1000, `cfg_valid` = 1.
- `up_p` and `dn_p` in the same cycle with `cfg_valid` = 0: `freq_idx` unchanged and `cfg_valid` stays 0. `up_p` and `wave_p` together: index +1, `wave_sel` +1, a single `cfg_valid`.
- `cfg_ready` = 0, then 5 `wave_p` pulses: `wave_sel` = 1 (5 mod 4); `cfg_valid` stays 1 until `cfg_ready`. A `wave_p` pulse in the same cycle as `cfg_ready` keeps `cfg_valid` = 1 with `wave_sel` = 2.
- After 2 `up_p` pulses (`freq_idx` = 6), assert `rst_n` = 0 mid-cycle: outputs return to reset values before the next edge, and `cfg_valid` = 1 after release.
